fp_cmp_pipe: RTL
================

Name: fp_cmp_pipe

Overview:
- Streaming, parametrised floating-point comparator for the decision-tree encoder datapath.
- Compares LANES operand pairs per transaction under a per-transaction mode.
- Results come from a STAGES-deep valid/ready pipeline.
- Generalises the single fp16 >= compare with:
  - configurable exponent/mantissa width;
  - four compare modes;
  - IEEE-correct signed-zero and NaN handling;
  - backpressure.

Parameters:
- EXP_W, 5, exponent field width in bits.
- MAN_W, 10, mantissa field width in bits (element width W = 1+EXP_W+MAN_W).
- LANES, 4, independent comparisons per transaction.
- STAGES, 2, pipeline register depth, legal range 1..8 (latency in cycles).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  input transaction valid.
- in_ready_o  output  1  pipeline accepts input this cycle.
- mode_i  input  2  0=GE (a>=b), 1=GT, 2=LT, 3=EQ; sampled with the transaction.
- operand_a_i  input  LANES*W  lane k occupies bits [k*W +: W].
- operand_b_i  input  LANES*W  same packing.
- out_valid_o  output  1  result transaction valid.
- out_ready_i  input  1  downstream accepts result.
- result_o  output  LANES  per-lane compare result.
- unord_o  output  LANES  per-lane unordered flag (a or b is NaN).

Behaviour:
Per-lane compare (combinational, feeds stage 0 register):
- NaN: exponent all ones and mantissa != 0.
- Magnitude key = {exp, man}, unsigned.
- Zero: key == 0. +0 and -0 compare equal.
- eq = both zero, or (signs equal and keys equal).
- a>b cases:
  - both zero: false.
  - signs differ: a>b iff sign_a==0.
  - both positive: key_a > key_b.
  - both negative: key_a < key_b.
- Infinities and subnormals need no special casing; the key order handles them.
- If either operand is NaN: result = 0 in every mode (EQ included) and unord = 1.
- Otherwise: unord = 0, and result = GE: gt|eq; GT: gt; LT: !gt & !eq; EQ: eq.

Pipeline:
- STAGES register stages, each holding valid, result and unord. The compare sits before stage 0; output comes from stage STAGES-1.
- Global advance: adv = out_ready_i | ~valid[STAGES-1]. in_ready_o = adv (combinational).
- On adv, every stage loads from its predecessor. Stage 0 loads (in_valid_i, compare result).
- When adv=0, all stages hold. Bubbles are not collapsed.
- Transfer rules:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - Simultaneous input and output transfer in the same cycle is legal and loses nothing.
- Unstalled latency: exactly STAGES cycles, accept edge to out_valid_o high. Throughput one transaction per cycle.
- Stability: while out_valid_o=1 and out_ready_i=0, result_o and unord_o hold stable.
- Data registers are not gated by valid. result_o and unord_o content is don't-care when out_valid_o=0.
- Reset:
  - Asynchronous, clears all valid bits and data registers to 0.
  - out_valid_o=0, result_o=0, unord_o=0.
  - in_ready_o=1 while in reset and afterwards.
  - Reset mid-stream discards all in-flight transactions with no partial outputs.
- mode_i is applied in the compare stage only. Changing mode between transactions affects only later transactions.

Test Plan:
- Defaults, GE, one lane per case, 1.0 vs 2.0 (0x3C00/0x4000), -1.0 vs -2.0 (0xBC00/0xC000), 2.0 vs 2.0, -0 vs +0 (0x8000/0x0000) -> result 0,1,1,1; unord 0; out_valid_o exactly 2 cycles after accept.
- EQ/GT/LT sweep on -2.0 vs -1.0 -> EQ 0, GT 0, LT 1; on +inf vs 0x7BFF -> GT 1; on subnormal 0x0001 vs 0x0000 -> GT 1.
- NaN 0x7E00 vs 1.0 in all four modes -> result 0, unord 1. The same with operands swapped -> result 0, unord 1.
- Backpressure: 10 back-to-back transactions, out_ready_i toggled with a 1-of-3 duty -> all 10 results delivered in order and matching the model; outputs stable while stalled; in_ready_o low only when stage STAGES-1 is valid and out_ready_i=0.
- Reset asserted while 2 transactions are in flight -> out_valid_o falls immediately (asynchronously); after release no stale result appears; the next transaction has normal latency.
- Parameter variants: STAGES=1, LANES=1; and EXP_W=8, MAN_W=7 (bf16), LANES=8 -> 0x3F80 (1.0) GE 0xBF80 (-1.0) gives 1; latency 1 cycle for STAGES=1; randomised run of 10k transactions against a reference model with zero mismatches.

Source files
------------

// File: rtl/fp_cmp_pipe_if.sv
// Handshake and data bundle for the fp_cmp_pipe streaming comparator.
// The master side produces transactions and consumes results; the slave
// side is the comparator pipeline itself.
interface fp_cmp_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int LANES = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [1:0]           mode_i;
    logic [LANES*W-1:0]   operand_a_i;
    logic [LANES*W-1:0]   operand_b_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [LANES-1:0]     result_o;
    logic [LANES-1:0]     unord_o;

    modport master (
        output in_valid_i, mode_i, operand_a_i, operand_b_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, unord_o
    );

    modport slave (
        input  in_valid_i, mode_i, operand_a_i, operand_b_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, unord_o
    );
endinterface

// File: rtl/fp_cmp_pipe.sv
// Streaming multi-lane floating-point comparator.
// Each transaction carries LANES operand pairs and a compare mode
// (0=GE, 1=GT, 2=LT, 3=EQ). The compare is combinational in front of a
// STAGES-deep valid/ready pipeline (legal STAGES range 1..8) that shifts as
// a whole whenever its tail can drain.
// Signed zeros compare equal; any NaN operand forces result 0 / unord 1.
module fp_cmp_pipe #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    fp_cmp_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int K = EXP_W + MAN_W;

    // One lane compare; returns {unord, result}.
    // The {exp, man} key orders magnitudes correctly for subnormals and
    // infinities, so only zero sign and NaN need explicit treatment.
    function automatic logic [1:0] lane_cmp(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   mode
    );
        logic         sa;
        logic         sb;
        logic [K-1:0] ka;
        logic [K-1:0] kb;
        logic         nan_a;
        logic         nan_b;
        logic         zero_both;
        logic         eq;
        logic         gt;
        logic         res;
        logic [1:0]   out;
        sa        = a[W-1];
        sb        = b[W-1];
        ka        = a[K-1:0];
        kb        = b[K-1:0];
        nan_a     = (&a[K-1:MAN_W]) & (|a[MAN_W-1:0]);
        nan_b     = (&b[K-1:MAN_W]) & (|b[MAN_W-1:0]);
        zero_both = ~(|ka) & ~(|kb);
        eq        = zero_both | ((sa == sb) & (ka == kb));
        if (zero_both) begin
            gt = 1'b0;
        end else if (sa != sb) begin
            gt = ~sa;
        end else if (!sa) begin
            gt = (ka > kb);
        end else begin
            gt = (ka < kb);
        end
        case (mode)
            2'd0:    res = gt | eq;
            2'd1:    res = gt;
            2'd2:    res = ~gt & ~eq;
            2'd3:    res = eq;
            default: res = 1'b0;
        endcase
        if (nan_a | nan_b) begin
            out = 2'b10;
        end else begin
            out = {1'b0, res};
        end
        return out;
    endfunction

    logic [LANES-1:0] cmp_res_s;
    logic [LANES-1:0] cmp_unord_s;
    logic             adv_s;

    logic             valid_r  [STAGES];
    logic [LANES-1:0] result_r [STAGES];
    logic [LANES-1:0] unord_r  [STAGES];

    // Evaluate every lane of the incoming transaction under its own mode.
    always_comb begin
        cmp_res_s   = {LANES{1'b0}};
        cmp_unord_s = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            {cmp_unord_s[k], cmp_res_s[k]} = lane_cmp(bus.operand_a_i[k*W +: W],
                                                      bus.operand_b_i[k*W +: W],
                                                      bus.mode_i);
        end
    end

    // The whole pipe moves when the tail is empty or being consumed.
    assign adv_s          = bus.out_ready_i | ~valid_r[STAGES-1];
    assign bus.in_ready_o = adv_s;
    assign bus.out_valid_o = valid_r[STAGES-1];
    assign bus.result_o    = result_r[STAGES-1];
    assign bus.unord_o     = unord_r[STAGES-1];

    // Pipeline registers: shift all stages together on advance, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_r[s]  <= 1'b0;
                result_r[s] <= {LANES{1'b0}};
                unord_r[s]  <= {LANES{1'b0}};
            end
        end else if (adv_s) begin
            valid_r[0]  <= bus.in_valid_i;
            result_r[0] <= cmp_res_s;
            unord_r[0]  <= cmp_unord_s;
            for (int s = 1; s < STAGES; s++) begin
                valid_r[s]  <= valid_r[s-1];
                result_r[s] <= result_r[s-1];
                unord_r[s]  <= unord_r[s-1];
            end
        end
    end
endmodule
